// File: rtl/c_tile_accumulator.sv
// c_tile_accumulator: sums partial-product C tiles into an NxN signed store
// and drains the finished matrix one row per beat.
module c_tile_accumulator #(
  parameter int unsigned N        = 4,
  parameter int unsigned IN_BITS  = 16,
  parameter int unsigned ACC_BITS = 32,
  parameter int unsigned SATURATE = 1,
  localparam int unsigned IDX_W   = (N > 1) ? $clog2(N) : 1
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              clear_i,
  input  logic                              in_valid_i,
  output logic                              in_ready_o,
  input  logic [N-1:0][IN_BITS-1:0]         in_row_i,
  input  logic                              in_first_i,
  input  logic                              in_last_i,
  output logic                              out_valid_o,
  input  logic                              out_ready_i,
  output logic [N-1:0][ACC_BITS-1:0]        out_row_o,
  output logic [IDX_W-1:0]                  out_row_idx_o,
  output logic                              ovf_o,
  output logic                              busy_o
);

  localparam logic [IDX_W-1:0]    LAST_ROW = IDX_W'(N - 1);
  localparam logic [ACC_BITS-1:0] ACC_MAX  = {1'b0, {(ACC_BITS-1){1'b1}}};
  localparam logic [ACC_BITS-1:0] ACC_MIN  = {1'b1, {(ACC_BITS-1){1'b0}}};

  typedef enum logic {ACCUM = 1'b0, DRAIN = 1'b1} state_t;

  state_t                         state_q, state_d;
  logic [IDX_W-1:0]               wr_row_q, wr_row_d;
  logic [IDX_W-1:0]               rd_row_q, rd_row_d;
  logic [N-1:0][N-1:0][ACC_BITS-1:0] acc_q;
  logic                           ovf_q, ovf_d;
  logic                           in_ready_q, in_ready_d;
  logic                           out_valid_q, out_valid_d;
  logic                           busy_q, busy_d;

  logic [N-1:0][ACC_BITS-1:0]     in_ext;
  logic [N-1:0][ACC_BITS:0]       sum;
  logic [N-1:0][ACC_BITS-1:0]     row_d;
  logic                           row_ovf;
  logic                           in_fire;
  logic                           out_fire;

  // A clear in the same cycle suppresses both handshakes.
  assign in_fire  = in_valid_i && in_ready_q && !clear_i;
  assign out_fire = out_valid_q && out_ready_i && !clear_i;

  // New contents of the row being written: overwrite on first tile, else widened add.
  always_comb begin
    in_ext  = '0;
    sum     = '0;
    row_d   = '0;
    row_ovf = 1'b0;
    for (int j = 0; j < int'(N); j++) begin
      in_ext[j] = ACC_BITS'($signed(in_row_i[j]));
      sum[j]    = {acc_q[wr_row_q][j][ACC_BITS-1], acc_q[wr_row_q][j]} +
                  {in_ext[j][ACC_BITS-1], in_ext[j]};
      if (in_first_i) begin
        row_d[j] = in_ext[j];
      end else if (sum[j][ACC_BITS] != sum[j][ACC_BITS-1]) begin
        row_ovf = 1'b1;
        if (SATURATE != 0) begin
          row_d[j] = sum[j][ACC_BITS] ? ACC_MIN : ACC_MAX;
        end else begin
          row_d[j] = sum[j][ACC_BITS-1:0];
        end
      end else begin
        row_d[j] = sum[j][ACC_BITS-1:0];
      end
    end
  end

  // State, pointers and registered status flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ACCUM;
      wr_row_q    <= '0;
      rd_row_q    <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_row_q    <= wr_row_d;
      rd_row_q    <= rd_row_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Next state and pointer movement.
  always_comb begin
    state_d  = state_q;
    wr_row_d = wr_row_q;
    rd_row_d = rd_row_q;
    if (clear_i) begin
      state_d  = ACCUM;
      wr_row_d = '0;
      rd_row_d = '0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (in_fire) begin
            if (wr_row_q == LAST_ROW) begin
              wr_row_d = '0;
              if (in_last_i) state_d = DRAIN;
            end else begin
              wr_row_d = wr_row_q + IDX_W'(1);
            end
          end
        end
        DRAIN: begin
          if (out_fire) begin
            if (rd_row_q == LAST_ROW) begin
              rd_row_d = '0;
              state_d  = ACCUM;
            end else begin
              rd_row_d = rd_row_q + IDX_W'(1);
            end
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  // Registered outputs derived from the next state; overflow set beats clear.
  always_comb begin
    ovf_d       = ovf_q;
    in_ready_d  = (state_d == ACCUM);
    out_valid_d = (state_d == DRAIN);
    busy_d      = (state_d == DRAIN) || (wr_row_d != '0);
    if (clear_i) begin
      ovf_d = 1'b0;
    end else if (in_fire) begin
      if ((wr_row_q == '0) && in_first_i) begin
        ovf_d = row_ovf;
      end else begin
        ovf_d = ovf_q | row_ovf;
      end
    end
  end

  // Accumulator store; contents survive a drain until overwritten.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else if (clear_i) begin
      acc_q <= '0;
    end else if (in_fire) begin
      acc_q[wr_row_q] <= row_d;
    end
  end

  assign in_ready_o    = in_ready_q;
  assign out_valid_o   = out_valid_q;
  assign busy_o        = busy_q;
  assign ovf_o         = ovf_q;
  assign out_row_o     = acc_q[rd_row_q];
  assign out_row_idx_o = rd_row_q;

endmodule

// File: tb/tb_c_tile_accumulator.sv
// Bench for c_tile_accumulator: three instances (32-bit saturating, 16-bit
// saturating, 16-bit wrapping) share one directed stimulus stream and are
// compared every cycle against a matrix-level model.
module tb_c_tile_accumulator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic in_valid = 1'b0;
  logic [3:0][15:0] in_row = '0;
  logic in_first = 1'b0;
  logic in_last = 1'b0;
  logic out_ready = 1'b0;

  logic in_ready_m, out_valid_m, ovf_m, busy_m;
  logic [3:0][31:0] row_m;
  logic [1:0] idx_m;
  logic in_ready_s, out_valid_s, ovf_s, busy_s;
  logic [3:0][15:0] row_s;
  logic [1:0] idx_s;
  logic in_ready_w, out_valid_w, ovf_w, busy_w;
  logic [3:0][15:0] row_w;
  logic [1:0] idx_w;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  c_tile_accumulator #(.N(4), .IN_BITS(16), .ACC_BITS(32), .SATURATE(1)) dut_m (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .in_valid_i(in_valid),
    .in_ready_o(in_ready_m), .in_row_i(in_row), .in_first_i(in_first),
    .in_last_i(in_last), .out_valid_o(out_valid_m), .out_ready_i(out_ready),
    .out_row_o(row_m), .out_row_idx_o(idx_m), .ovf_o(ovf_m), .busy_o(busy_m));

  c_tile_accumulator #(.N(4), .IN_BITS(16), .ACC_BITS(16), .SATURATE(1)) dut_s (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .in_valid_i(in_valid),
    .in_ready_o(in_ready_s), .in_row_i(in_row), .in_first_i(in_first),
    .in_last_i(in_last), .out_valid_o(out_valid_s), .out_ready_i(out_ready),
    .out_row_o(row_s), .out_row_idx_o(idx_s), .ovf_o(ovf_s), .busy_o(busy_s));

  c_tile_accumulator #(.N(4), .IN_BITS(16), .ACC_BITS(16), .SATURATE(0)) dut_w (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .in_valid_i(in_valid),
    .in_ready_o(in_ready_w), .in_row_i(in_row), .in_first_i(in_first),
    .in_last_i(in_last), .out_valid_o(out_valid_w), .out_ready_i(out_ready),
    .out_row_o(row_w), .out_row_idx_o(idx_w), .ovf_o(ovf_w), .busy_o(busy_w));

  task automatic chk(input string nm, input longint got, input longint want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, want, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int     bits [3] = '{32, 16, 16};
  bit     sat  [3] = '{1'b1, 1'b1, 1'b0};
  longint m_acc [3][4][4];
  bit     m_ovf [3];
  bit     m_drain;
  bit     m_alive;
  int     m_wr, m_rd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      foreach (m_acc[k, r, j]) m_acc[k][r][j] = 0;
      foreach (m_ovf[k]) m_ovf[k] = 1'b0;
      m_drain = 1'b0; m_alive = 1'b0; m_wr = 0; m_rd = 0;
    end else begin
      m_alive = 1'b1;
      if (clear) begin
        foreach (m_acc[k, r, j]) m_acc[k][r][j] = 0;
        foreach (m_ovf[k]) m_ovf[k] = 1'b0;
        m_drain = 1'b0; m_wr = 0; m_rd = 0;
      end else if (!m_drain && in_valid) begin
        for (int k = 0; k < 3; k++) begin
          longint mx, mn, x, s;
          bit ov;
          mx = (longint'(1) <<< (bits[k] - 1)) - 1;
          mn = -mx - 1;
          ov = 1'b0;
          for (int j = 0; j < 4; j++) begin
            x = longint'($signed(in_row[j]));
            if (in_first) s = x;
            else begin
              s = m_acc[k][m_wr][j] + x;
              if (s > mx || s < mn) begin
                ov = 1'b1;
                if (sat[k]) s = (s > mx) ? mx : mn;
                else s = (s <<< (64 - bits[k])) >>> (64 - bits[k]);
              end
            end
            m_acc[k][m_wr][j] = s;
          end
          if (m_wr == 0 && in_first) m_ovf[k] = ov;
          else m_ovf[k] = m_ovf[k] | ov;
        end
        if (m_wr == 3 && in_last) m_drain = 1'b1;
        m_wr = (m_wr + 1) % 4;
      end else if (m_drain && out_ready) begin
        m_rd = m_rd + 1;
        if (m_rd == 4) begin
          m_rd = 0;
          m_drain = 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison of all instances against the model.
  always @(negedge clk) begin
    chk("in_ready", longint'(in_ready_m), longint'(m_alive && !m_drain));
    chk("out_valid", longint'(out_valid_m), longint'(m_drain));
    chk("busy", longint'(busy_m), longint'(m_drain || m_wr != 0));
    chk("ovf_m", longint'(ovf_m), longint'(m_ovf[0]));
    chk("ovf_s", longint'(ovf_s), longint'(m_ovf[1]));
    chk("ovf_w", longint'(ovf_w), longint'(m_ovf[2]));
    chk("valid_sw", longint'({out_valid_s, out_valid_w}), m_drain ? 3 : 0);
    if (m_drain) begin
      chk("row_idx", longint'(idx_m), longint'(m_rd));
      for (int j = 0; j < 4; j++) begin
        chk("row_m", longint'($signed(row_m[j])), m_acc[0][m_rd][j]);
        chk("row_s", longint'($signed(row_s[j])), m_acc[1][m_rd][j]);
        chk("row_w", longint'($signed(row_w[j])), m_acc[2][m_rd][j]);
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [3:0][15:0] mkrow(input int base, input int stp);
    logic [3:0][15:0] r;
    for (int j = 0; j < 4; j++) r[j] = 16'(base + stp * j);
    return r;
  endfunction

  task automatic beat(input logic [3:0][15:0] row, input bit f, input bit l, input bit clr);
    @(negedge clk); #1;
    in_valid = 1'b1; in_row = row; in_first = f; in_last = l;
    clear = clr; out_ready = 1'b0;
  endtask

  task automatic step(input bit rdy);
    @(negedge clk); #1;
    in_valid = 1'b0; clear = 1'b0; out_ready = rdy;
  endtask

  task automatic drain_all();
    for (int i = 0; i < 4; i++) step(1'b1);
    step(1'b0);
  endtask

  bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    logic [3:0][15:0] r;
    #3;
    chk("lit_reset_ready", longint'(in_ready_m), 0);
    @(negedge clk); #1;
    rst_n = 1'b1;

    // single tile: element j of row r = r*4+j
    for (int rr = 0; rr < 4; rr++) beat(mkrow(rr * 4, 1), 1'b1, 1'b1, 1'b0);
    step(1'b0);
    chk("lit_single_valid", longint'(out_valid_m), 1);
    chk("lit_single_e02", longint'($signed(row_m[2])), 2);
    chk("lit_single_ovf", longint'(ovf_m), 0);
    drain_all();
    chk("lit_single_ready_after", longint'(in_ready_m), 1);

    // three tiles 5, -2, 7
    for (int rr = 0; rr < 4; rr++) beat(mkrow(5, 0), 1'b1, 1'b0, 1'b0);
    for (int rr = 0; rr < 4; rr++) beat(mkrow(-2, 0), 1'b0, 1'b0, 1'b0);
    for (int rr = 0; rr < 4; rr++) beat(mkrow(7, 0), 1'b0, 1'b1, 1'b0);
    step(1'b0);
    chk("lit_three_e00", longint'($signed(row_m[0])), 10);
    chk("lit_three_ready", longint'(in_ready_m), 0);
    drain_all();

    // saturation / wrap on element [1][2], with stalled drain
    for (int rr = 0; rr < 4; rr++) begin
      r = '0;
      if (rr == 1) r[2] = 16'h7000;
      beat(r, 1'b1, 1'b0, 1'b0);
    end
    for (int rr = 0; rr < 4; rr++) begin
      r = '0;
      if (rr == 1) r[2] = 16'h2000;
      beat(r, 1'b0, 1'b1, 1'b0);
    end
    step(1'b0);
    chk("lit_sat_ovf_s", longint'(ovf_s), 1);
    chk("lit_sat_ovf_w", longint'(ovf_w), 1);
    chk("lit_sat_ovf_m", longint'(ovf_m), 0);
    for (int i = 0; i < 7; i++) begin
      step(pat[i]);
      if (i == 1) begin
        chk("lit_stall_idx", longint'(idx_m), 1);
        chk("lit_sat_7fff", longint'(row_s[2]), 32'h7FFF);
        chk("lit_wrap_9000", longint'(row_w[2]), 32'h9000);
        chk("lit_wide_sum", longint'(row_m[2]), 36864);
      end
    end
    step(1'b0);
    chk("lit_bp_ready_after", longint'(in_ready_m), 1);
    beat(mkrow(0, 0), 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("lit_ovf_cleared", longint'(ovf_s), 0);
    for (int rr = 1; rr < 4; rr++) beat(mkrow(0, 0), 1'b1, 1'b1, 1'b0);
    step(1'b0);
    drain_all();

    // clear after two rows of tile 1
    beat(mkrow(9, 0), 1'b1, 1'b1, 1'b0);
    beat(mkrow(9, 0), 1'b1, 1'b1, 1'b0);
    beat(mkrow(9, 0), 1'b1, 1'b1, 1'b1);
    step(1'b0);
    chk("lit_clear_busy", longint'(busy_m), 0);
    for (int rr = 0; rr < 4; rr++) beat(mkrow(100 + rr * 4, 1), 1'b1, 1'b1, 1'b0);
    step(1'b0);
    drain_all();

    // async reset during drain row 1
    for (int rr = 0; rr < 4; rr++) beat(mkrow(-50 + rr, 3), 1'b1, 1'b1, 1'b0);
    step(1'b0);
    step(1'b1);
    @(negedge clk); #1;
    out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("lit_rst_valid", longint'(out_valid_m), 0);
    chk("lit_rst_ready", longint'(in_ready_m), 0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    step(1'b0);
    chk("lit_rst_ready_after", longint'(in_ready_m), 1);

    // clear coincident with final beat of a last tile
    for (int rr = 0; rr < 3; rr++) beat(mkrow(3, 0), 1'b1, 1'b1, 1'b0);
    beat(mkrow(3, 0), 1'b1, 1'b1, 1'b1);
    step(1'b0);
    chk("lit_clrlast_ready", longint'(in_ready_m), 1);
    chk("lit_clrlast_valid", longint'(out_valid_m), 0);
    for (int rr = 0; rr < 4; rr++) beat(mkrow(1, 0), 1'b0, 1'b1, 1'b0);
    step(1'b0);
    chk("lit_add_to_zero", longint'($signed(row_m[3])), 1);
    drain_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/c_tile_accumulator.md
Name: c_tile_accumulator

Overview:
- Output-side accumulator for the systolic matrix-multiply array.
- Receives partial-product C tiles one row per beat (N elements), sums them over K tiles into an internal NxN ACC_BITS-wide signed store, and drains the finished matrix one row per beat.
- Generalises the fixed-width row accumulator with:
  - parametrised N and accumulator width,
  - first/last tile framing,
  - optional saturation with a sticky overflow flag,
  - valid/ready handshakes on both sides,
  - a synchronous flush.

Parameters:
- N, 4, matrix dimension: rows per tile and elements per row.
- IN_BITS, 16, signed width of each incoming partial-product element.
- ACC_BITS, 32, signed width of each accumulator element; must be at least IN_BITS.
- SATURATE, 1, 1 = clamp on signed overflow; 0 = two's-complement wrap.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- clear_i  in  1  synchronous flush; highest priority.
- in_valid_i  in  1  input row valid.
- in_ready_o  out  1  input row accepted when in_valid_i and in_ready_o are both 1.
- in_row_i  in  N x IN_BITS  one row of partial products, element j = column j, signed.
- in_first_i  in  1  row belongs to the first K-tile: overwrite instead of add.
- in_last_i  in  1  row belongs to the final K-tile: matrix completes after this tile.
- out_valid_o  out  1  drain row valid.
- out_ready_i  in  1  downstream accepts the drain row.
- out_row_o  out  N x ACC_BITS  accumulated row, signed.
- out_row_idx_o  out  $clog2(N) (min 1)  index of the row on out_row_o.
- ovf_o  out  1  sticky: a saturation or wrap occurred in the current matrix.
- busy_o  out  1  high when in DRAIN, or when the write pointer is non-zero.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - all accumulators 0; wr_row = 0, rd_row = 0; state ACCUM.
  - ovf_o = 0, out_valid_o = 0, busy_o = 0.
  - in_ready_o = 0 while rst_ni is low.
  - Reset mid-tile or mid-drain discards everything.
- States: ACCUM and DRAIN.
  - in_ready_o = 1 only in ACCUM.
  - out_valid_o = 1 only in DRAIN.
- ACCUM, on an accepted beat, with sext() = sign-extend to ACC_BITS:
  - acc[wr_row][j] <= sext(in_row_i[j]) if in_first_i = 1.
  - Otherwise acc[wr_row][j] <= acc[wr_row][j] + sext(in_row_i[j]).
  - The add is computed ACC_BITS+1 wide.
  - Overflow with SATURATE = 1: clamp to +2^(ACC_BITS-1)-1 or -2^(ACC_BITS-1).
  - Overflow with SATURATE = 0: keep the low ACC_BITS.
  - Either overflow case sets ovf_o.
- Write pointer:
  - wr_row increments per accepted beat and wraps N-1 -> 0 (tile boundary).
  - in_first_i and in_last_i are sampled per beat; the producer holds them constant across a tile.
  - in_last_i on the beat with wr_row = N-1 -> state DRAIN next cycle.
  - Otherwise the block stays in ACCUM for the next tile.
- ovf_o clear: cleared on an accepted beat with wr_row = 0 and in_first_i = 1. Overflow detected on that same beat still sets it; set wins.
- DRAIN:
  - out_row_o = acc[rd_row]; out_row_idx_o = rd_row.
  - Both are stable while out_valid_o = 1 and out_ready_i = 0.
  - On out_ready_i, rd_row increments.
  - Handshake at rd_row = N-1: rd_row -> 0, state ACCUM, out_valid_o drops the next cycle.
  - Accumulator contents are retained after drain; the next matrix overwrites them via in_first_i.
- Latency:
  - First drain row is valid 1 cycle after the last input beat is accepted.
  - Full drain takes N cycles with out_ready_i held high.
  - No input is accepted during DRAIN (back-pressure).
- clear_i = 1 (any state):
  - next cycle: acc all 0, pointers 0, ACCUM, ovf_o = 0.
  - An input or output handshake in the same cycle is ignored: nothing is written and no pointer moves.
- Beat with in_first_i = 0 on the very first tile after reset or clear: adds to zero; this is legal.
- N = 1: every accepted beat is a full tile.

Test Plan:
- Single-tile matrix: N=4, one tile with in_first_i = in_last_i = 1, rows r with element j = r*4+j -> drain rows 0..3 output the same values; out_row_idx_o = 0,1,2,3; ovf_o = 0.
- Three-tile accumulate: tile 1 all elements 5 (first), tile 2 all -2, tile 3 all 7 (last) -> every output element = 10; no drain before the tile-3 row 3 beat; in_ready_o = 0 throughout the drain.
- Saturation: ACC_BITS = 16, IN_BITS = 16, SATURATE = 1, tiles of 0x7000 and 0x2000 on element [1][2] -> output 0x7FFF, ovf_o = 1. With SATURATE = 0 -> 0x9000, ovf_o = 1. Next matrix's first-tile row 0 beat clears ovf_o.
- Drain back-pressure: toggle out_ready_i as 1,0,0,1,0,1,1 -> rows emitted in order 0..3, each stable while stalled, exactly 4 handshakes, then in_ready_o = 1.
- Mid-operation events:
  - clear_i after 2 of 4 rows of tile 1 -> wr_row = 0, next 4-row single tile drains correctly.
  - rst_ni pulsed low during drain row 1 -> out_valid_o = 0 immediately, all state reset.
- Simultaneous clear_i and input handshake on a tile's final beat with in_last_i = 1 -> no DRAIN entered, accumulators 0, in_ready_o = 1 next cycle.
